// File: rtl/ysyx_22040931_store_buffer.sv
// rtl/ysyx_22040931_store_buffer.sv - FIFO store buffer producing 8-byte-aligned masked write beats
//
// Optional feature macro: YSYX_22040931_STORE_FWD_EN
//   defined   : ld_hit reports whether any buffered store covers the 8-byte line of ld_addr
//   undefined : ld_hit is tied low and ld_addr is ignored
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid/in_ready              store request handshake from EX
//   in_memwop, in_addr, in_data    store size code, byte address, right-aligned data
//   mem_valid/mem_ready            write beat handshake toward memory
//   mem_addr, mem_wdata, mem_wmask head entry: aligned address, lane-shifted data, byte mask
//   misalign_err, misalign_addr    one-cycle pulse and faulting address of a misaligned store
//   count, empty                   occupancy
//   ld_addr, ld_hit                load-conflict probe

module ysyx_22040931_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 64,
    parameter int DW    = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_memwop,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    output logic [7:0]               mem_wmask,
    output logic                     misalign_err,
    output logic [AW-1:0]            misalign_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [7:0]       ent_mask [DEPTH];
    logic [DEPTH-1:0] ent_vld;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;

    logic             full;
    logic             op_ok;
    logic [7:0]       size_mask;
    logic [2:0]       align_mask;
    logic             misaligned;
    logic             accept;
    logic             push;
    logic             pop;
    logic             err_set;
    logic [2:0]       byte_off;
    logic [7:0]       push_mask;
    logic [DW-1:0]    push_data;
    logic [AW-1:0]    push_addr;

    // Size decode: align_mask holds the low address bits that must be zero.
    always_comb begin
        op_ok      = 1'b0;
        size_mask  = 8'h00;
        align_mask = 3'b000;
        case (in_memwop)
            3'b001: begin op_ok = 1'b1; size_mask = 8'h01; align_mask = 3'b000; end
            3'b010: begin op_ok = 1'b1; size_mask = 8'h03; align_mask = 3'b001; end
            3'b011: begin op_ok = 1'b1; size_mask = 8'h0f; align_mask = 3'b011; end
            3'b100: begin op_ok = 1'b1; size_mask = 8'hff; align_mask = 3'b111; end
            default: begin op_ok = 1'b0; size_mask = 8'h00; align_mask = 3'b000; end
        endcase
    end

    assign full       = (cnt == CW'(DEPTH));
    assign in_ready   = !full;
    assign empty      = (cnt == '0);
    assign mem_valid  = !empty;
    assign count      = cnt;

    assign misaligned = |(in_addr[2:0] & align_mask);
    assign accept     = in_valid && in_ready;
    // Misaligned and no-op requests are consumed so EX never stalls on them.
    assign push       = accept && op_ok && !misaligned;
    assign err_set    = accept && op_ok && misaligned;
    assign pop        = mem_valid && mem_ready;

    assign byte_off   = in_addr[2:0];
    assign push_mask  = size_mask << byte_off;
    assign push_data  = in_data << {byte_off, 3'b000};
    assign push_addr  = {in_addr[AW-1:3], 3'b000};

    // Head entry drives the write beat directly; it only changes on a pop,
    // so it is stable while the memory side stalls.
    assign mem_addr   = ent_addr[head];
    assign mem_wdata  = ent_data[head];
    assign mem_wmask  = ent_mask[head];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head          <= '0;
            tail          <= '0;
            cnt           <= '0;
            ent_vld       <= '0;
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            if (push) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            misalign_err <= err_set;
            if (err_set) begin
                misalign_addr <= in_addr;
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by cnt/ent_vld.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            ent_addr[tail] <= push_addr;
            ent_data[tail] <= push_data;
            ent_mask[tail] <= push_mask;
        end
    end

`ifdef YSYX_22040931_STORE_FWD_EN
    logic [AW-1:0] ld_key;

    assign ld_key = {ld_addr[AW-1:3], 3'b000};

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == ld_key)) begin
                ld_hit = 1'b1;
            end
        end
    end
`else
    logic unused_probe;

    assign ld_hit       = 1'b0;
    assign unused_probe = &{1'b0, ld_addr, ent_vld, 1'b0};
`endif

endmodule

// File: tb/tb_ysyx_22040931_store_buffer.sv
// tb/tb_ysyx_22040931_store_buffer.sv - self-checking bench for ysyx_22040931_store_buffer
module tb_ysyx_22040931_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_memwop;
    logic [63:0] in_addr;
    logic [63:0] in_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        misalign_err;
    logic [63:0] misalign_addr;
    logic [2:0]  count;
    logic        empty;
    logic [63:0] ld_addr;
    logic        ld_hit;

    int checks   = 0;
    int failures = 0;

    ysyx_22040931_store_buffer #(.DEPTH(DEPTH), .AW(64), .DW(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_memwop(in_memwop),
        .in_addr(in_addr), .in_data(in_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .misalign_err(misalign_err), .misalign_addr(misalign_addr),
        .count(count), .empty(empty),
        .ld_addr(ld_addr), .ld_hit(ld_hit)
    );

    always #5 clk = ~clk;

`ifdef YSYX_22040931_STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending write beats plus the error pulse.
    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  m;
    } ent_t;

    ent_t        q[$];
    logic        e_err   = 1'b0;
    logic [63:0] e_maddr = '0;
    bit          started = 1'b0;

    function automatic int size_of(input logic [2:0] wop);
        case (wop)
            3'd1: return 1;
            3'd2: return 2;
            3'd3: return 4;
            3'd4: return 8;
            default: return 0;
        endcase
    endfunction

    // Outputs are compared at the falling edge against the model state, then
    // the model absorbs the inputs that the next rising edge will see.
    always @(negedge clk) begin
        if (started) begin
            logic exp_hit;
            exp_hit = 1'b0;
            foreach (q[i]) if (q[i].a == (ld_addr & ~64'h7)) exp_hit = 1'b1;
            chk("in_ready", in_ready, q.size() < DEPTH);
            chk("mem_valid", mem_valid, q.size() > 0);
            chk("count", count, q.size());
            chk("empty", empty, q.size() == 0);
            if (q.size() > 0) begin
                chk("mem_addr", mem_addr, q[0].a);
                chk("mem_wdata", mem_wdata, q[0].d);
                chk("mem_wmask", mem_wmask, q[0].m);
            end
            chk("misalign_err", misalign_err, e_err);
            if (e_err) chk("misalign_addr", misalign_addr, e_maddr);
            chk("ld_hit", ld_hit, FWD ? exp_hit : 1'b0);
        end
        if (!rst_n) begin
            q.delete();
            e_err   = 1'b0;
            e_maddr = '0;
            started = 1'b1;
        end else if (started) begin
            int   sz;
            int   off;
            bit   acc;
            bit   al;
            ent_t e;
            sz  = size_of(in_memwop);
            off = int'(in_addr[2:0]);
            acc = in_valid && (q.size() < DEPTH);
            al  = (sz != 0) && ((in_addr % 64'(sz)) == 0);
            if (q.size() > 0 && mem_ready) void'(q.pop_front());
            if (acc && al) begin
                e.a = in_addr & ~64'h7;
                e.d = in_data << (8 * off);
                e.m = '0;
                for (int k = 0; k < sz; k++) e.m[off + k] = 1'b1;
                q.push_back(e);
            end
            e_err = acc && (sz != 0) && !al;
            if (e_err) e_maddr = in_addr;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_memwop = 3'd0;
        in_addr   = '0;
        in_data   = '0;
        mem_ready = 1'b0;
        ld_addr   = '0;
        repeat (3) cyc();
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_mem_valid", mem_valid, 0);
        chk("reset_err", misalign_err, 0);
        chk("reset_maddr", misalign_addr, 0);
        rst_n = 1'b1;
        cyc();

        // Byte store at offset 3 with memory always ready.
        mem_ready = 1'b1;
        in_valid  = 1'b1; in_memwop = 3'b001;
        in_addr   = 64'h8000_0003; in_data = 64'hab;
        cyc();
        in_valid = 1'b0;
        chk("sb_mem_valid", mem_valid, 1);
        chk("sb_mem_addr", mem_addr, 64'h8000_0000);
        chk("sb_wmask", mem_wmask, 8'h08);
        chk("sb_wdata", mem_wdata, 64'h0000_0000_ab00_0000);
        cyc();
        chk("sb_empty_after_pop", empty, 1);

        // Misaligned word.
        in_valid = 1'b1; in_memwop = 3'b011; in_addr = 64'h8000_0002; in_data = 64'h1234;
        cyc();
        in_valid = 1'b0;
        chk("sw_mis_err", misalign_err, 1);
        chk("sw_mis_addr", misalign_addr, 64'h8000_0002);
        chk("sw_mis_empty", empty, 1);
        cyc();
        chk("sw_mis_err_pulse", misalign_err, 0);

        // Fill with five dword stores while memory stalls.
        mem_ready = 1'b0;
        in_valid  = 1'b1; in_memwop = 3'b100;
        for (int i = 0; i < 5; i++) begin
            in_addr = 64'h10 + 64'(8 * i);
            in_data = 64'(i + 1);
            cyc();
            if (i == 3) begin
                chk("fill_in_ready", in_ready, 0);
                chk("fill_count", count, 4);
            end
        end
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", mem_addr, 64'h10 + 64'(8 * i));
            chk("drain_data", mem_wdata, 64'(i + 1));
            cyc();
        end
        chk("drain_empty", empty, 1);

        // Push and pop together at count 2.
        mem_ready = 1'b0;
        in_valid  = 1'b1; in_memwop = 3'b100;
        in_addr = 64'h100; in_data = 64'ha; cyc();
        in_addr = 64'h108; in_data = 64'hb; cyc();
        chk("pp_count_before", count, 2);
        mem_ready = 1'b1;
        in_addr = 64'h110; in_data = 64'hc; cyc();
        in_valid = 1'b0;
        chk("pp_count", count, 2);
        chk("pp_head", mem_addr, 64'h108);
        cyc();
        chk("pp_next", mem_wdata, 64'hc);
        cyc();
        chk("pp_empty", empty, 1);

        // Reset with three entries outstanding.
        mem_ready = 1'b0;
        in_valid  = 1'b1; in_memwop = 3'b100;
        for (int i = 0; i < 3; i++) begin
            in_addr = 64'h200 + 64'(8 * i); cyc();
        end
        in_valid = 1'b0;
        chk("rst_pre_count", count, 3);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_empty", empty, 1);

        // Load-conflict probe.
        in_valid = 1'b1; in_memwop = 3'b100; in_addr = 64'h8000_0010; in_data = 64'h5;
        cyc();
        in_valid = 1'b0;
        ld_addr = 64'h8000_0014; #1;
        chk("ld_hit_same_line", ld_hit, FWD ? 1'b1 : 1'b0);
        ld_addr = 64'h8000_0018; #1;
        chk("ld_hit_other_line", ld_hit, 0);
        mem_ready = 1'b1;
        cyc();
        cyc();

        // Randomised traffic; the model process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            in_valid  = $urandom_range(0, 2) != 0;
            in_memwop = 3'($urandom_range(0, 7));
            in_addr   = 64'h8000_0000 + 64'($urandom_range(0, 63));
            in_data   = {$urandom, $urandom};
            mem_ready = $urandom_range(0, 2) == 0;
            ld_addr   = 64'h8000_0000 + 64'($urandom_range(0, 63));
            cyc();
        end
        rst_n = 1'b1; in_valid = 1'b0; mem_ready = 1'b1;
        repeat (8) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
